// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU flag positions, branch condition codes and condition evaluation
package cpu_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam int FLAGS_W             = 8;
    localparam int STACK_DEPTH_DEFAULT = 4;

    typedef enum logic [3:0] {
        COND_AL = 4'h0,
        COND_EQ = 4'h1,
        COND_NE = 4'h2,
        COND_CS = 4'h3,
        COND_CC = 4'h4,
        COND_MI = 4'h5,
        COND_PL = 4'h6,
        COND_VS = 4'h7,
        COND_VC = 4'h8,
        COND_HI = 4'h9,
        COND_LS = 4'hA,
        COND_GE = 4'hB,
        COND_LT = 4'hC,
        COND_GT = 4'hD,
        COND_LE = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // C is a borrow flag: C=1 means unsigned a<b after SUB/CMP, so HI is ~C&~Z.
    function automatic logic eval_cond(input logic [FLAGS_W-1:0] f, input logic [3:0] cc);
        logic c, z, n, v;
        logic r;
        c = f[FLAG_C];
        z = f[FLAG_Z];
        n = f[FLAG_N];
        v = f[FLAG_V];
        r = 1'b0;
        case (cond_e'(cc))
            COND_AL: r = 1'b1;
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = ~c & ~z;
            COND_LS: r = c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flags_stack.sv
// rtl/flags_stack.sv - LIFO shadow stack for flags save/restore on interrupt entry/return
module flags_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH_DEFAULT,
    parameter int W     = FLAGS_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         pop_ok,
    output logic         full,
    output logic         empty,
    output logic         err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  count_q;
    logic [AW:0]  top_idx;
    logic         push_ok;
    logic         bad_req;
    logic         err_q;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign top_idx = count_q - 1'b1;

    // Simultaneous push and pop is treated as illegal: neither takes effect.
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign bad_req = (push & pop) | (push & full) | (pop & empty);

    assign pop_data = mem[top_idx[AW-1:0]];
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bad_req;
            if (push_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage is not reset; a cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[count_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/flags_unit.sv
// rtl/flags_unit.sv - CPU flags register with shadow stack and branch condition evaluation
module flags_unit
    import cpu_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLAGS_W-1:0] alu_flags,
    input  logic               update_en,
    input  logic               sw_wr_en,
    input  logic [FLAGS_W-1:0] sw_wr_data,
    input  logic               push,
    input  logic               pop,
    input  logic [3:0]         cond_code,
    output logic [FLAGS_W-1:0] flags_q,
    output logic               cond_true,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               stack_err
);

    logic [FLAGS_W-1:0] restore_data;
    logic               restore_ok;
    logic [FLAGS_W-1:0] flags_reg;

    // The stack captures the pre-edge register value, so a same-cycle update never leaks in.
    flags_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (FLAGS_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (flags_reg),
        .pop_data  (restore_data),
        .pop_ok    (restore_ok),
        .full      (stack_full),
        .empty     (stack_empty),
        .err       (stack_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_reg <= '0;
        end else if (restore_ok) begin
            flags_reg <= restore_data;
        end else if (sw_wr_en) begin
            flags_reg <= sw_wr_data;
        end else if (update_en) begin
            flags_reg <= alu_flags;
        end
    end

    assign flags_q   = flags_reg;
    assign cond_true = eval_cond(flags_reg, cond_code);

endmodule

// File: tb/tb_flags_unit.sv
// tb/tb_flags_unit.sv - directed self-checking bench for flags_unit
module tb_flags_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_flags;
    logic       update_en;
    logic       sw_wr_en;
    logic [7:0] sw_wr_data;
    logic       push;
    logic       pop;
    logic [3:0] cond_code;
    logic [7:0] flags_q;
    logic       cond_true;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int checks   = 0;
    int failures = 0;

    flags_unit #(.STACK_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_flags   (alu_flags),
        .update_en   (update_en),
        .sw_wr_en    (sw_wr_en),
        .sw_wr_data  (sw_wr_data),
        .push        (push),
        .pop         (pop),
        .cond_code   (cond_code),
        .flags_q     (flags_q),
        .cond_true   (cond_true),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic idle();
        update_en = 1'b0;
        sw_wr_en  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sw_write(input logic [7:0] d);
        sw_wr_en   = 1'b1;
        sw_wr_data = d;
        step();
    endtask

    // Reference condition table, C=bit0 Z=bit1 N=bit2 V=bit3.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cc);
        logic c, z, n, v;
        c = f[0]; z = f[1]; n = f[2]; v = f[3];
        case (cc)
            4'h0: return 1'b1;
            4'h1: return z;
            4'h2: return !z;
            4'h3: return c;
            4'h4: return !c;
            4'h5: return n;
            4'h6: return !n;
            4'h7: return v;
            4'h8: return !v;
            4'h9: return !c && !z;
            4'hA: return c || z;
            4'hB: return n == v;
            4'hC: return n != v;
            4'hD: return !z && (n == v);
            4'hE: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        rst_n      = 1'b0;
        alu_flags  = 8'h00;
        sw_wr_data = 8'h00;
        cond_code  = 4'h0;
        idle();
        step();
        step();
        check_eq("rst_flags", flags_q, 8'h00);
        check_eq("rst_empty", {7'd0, stack_empty}, 8'h01);
        check_eq("rst_full", {7'd0, stack_full}, 8'h00);
        check_eq("rst_err", {7'd0, stack_err}, 8'h00);
        rst_n = 1'b1;

        // ALU update: Z and N set
        update_en = 1'b1;
        alu_flags = 8'h06;
        #1;
        check_eq("upd_not_comb", flags_q, 8'h00);
        step();
        check_eq("upd_flags", flags_q, 8'h06);
        cond_code = 4'h1; #1; check_eq("upd_eq", {7'd0, cond_true}, 8'h01);
        cond_code = 4'h5; #1; check_eq("upd_mi", {7'd0, cond_true}, 8'h01);
        cond_code = 4'hB; #1; check_eq("upd_ge", {7'd0, cond_true}, 8'h00);
        cond_code = 4'hC; #1; check_eq("upd_lt", {7'd0, cond_true}, 8'h01);

        // Full condition sweep; nonzero reserved bits must not disturb evaluation
        for (int f = 0; f < 16; f++) begin
            sw_write({4'hA, 4'(f)});
            check_eq("sweep_flags", flags_q, {4'hA, 4'(f)});
            for (int cc = 0; cc < 16; cc++) begin
                cond_code = 4'(cc);
                #1;
                check_eq($sformatf("cond_f%0h_c%0h", f, cc), {7'd0, cond_true},
                         {7'd0, ref_cond(4'(f), 4'(cc))});
            end
        end

        // Push stores pre-edge value despite same-cycle update
        sw_write(8'hA5);
        push      = 1'b1;
        update_en = 1'b1;
        alu_flags = 8'h02;
        step();
        check_eq("pu_flags", flags_q, 8'h02);
        check_eq("pu_empty", {7'd0, stack_empty}, 8'h00);
        pop = 1'b1;
        step();
        check_eq("pu_restore", flags_q, 8'hA5);
        check_eq("pu_empty2", {7'd0, stack_empty}, 8'h01);
        check_eq("pu_err", {7'd0, stack_err}, 8'h00);

        // Fill to depth then overflow
        for (int i = 1; i <= 5; i++) begin
            sw_write(8'(i));
            push = 1'b1;
            step();
            check_eq($sformatf("fill_err%0d", i), {7'd0, stack_err}, (i == 5) ? 8'h01 : 8'h00);
            check_eq($sformatf("fill_full%0d", i), {7'd0, stack_full}, (i >= 4) ? 8'h01 : 8'h00);
        end
        step();
        check_eq("ovf_err_clear", {7'd0, stack_err}, 8'h00);
        for (int i = 4; i >= 1; i--) begin
            pop = 1'b1;
            step();
            check_eq($sformatf("drain%0d", i), flags_q, 8'(i));
            check_eq($sformatf("drain_err%0d", i), {7'd0, stack_err}, 8'h00);
        end
        check_eq("drain_empty", {7'd0, stack_empty}, 8'h01);
        check_eq("drain_full", {7'd0, stack_full}, 8'h00);
        pop = 1'b1;
        step();
        check_eq("unf_err", {7'd0, stack_err}, 8'h01);
        check_eq("unf_flags", flags_q, 8'h01);
        step();
        check_eq("unf_err_clear", {7'd0, stack_err}, 8'h00);

        // Pop while empty lets software write through
        pop        = 1'b1;
        sw_wr_en   = 1'b1;
        sw_wr_data = 8'h5A;
        step();
        check_eq("unf_sw_flags", flags_q, 8'h5A);
        check_eq("unf_sw_err", {7'd0, stack_err}, 8'h01);

        // Restore beats software write
        sw_write(8'h77);
        push = 1'b1;
        step();
        pop        = 1'b1;
        sw_wr_en   = 1'b1;
        sw_wr_data = 8'h3C;
        step();
        check_eq("prio_flags", flags_q, 8'h77);
        check_eq("prio_empty", {7'd0, stack_empty}, 8'h01);

        // Push+pop together: both ignored, ALU update still applies
        push = 1'b1;
        step();
        push      = 1'b1;
        pop       = 1'b1;
        update_en = 1'b1;
        alu_flags = 8'h11;
        step();
        check_eq("pp_err", {7'd0, stack_err}, 8'h01);
        check_eq("pp_flags", flags_q, 8'h11);
        check_eq("pp_empty", {7'd0, stack_empty}, 8'h00);
        pop = 1'b1;
        step();
        check_eq("pp_restore", flags_q, 8'h77);
        check_eq("pp_empty2", {7'd0, stack_empty}, 8'h01);

        // Reset discards stacked entries
        sw_write(8'hFF);
        push = 1'b1;
        step();
        push = 1'b1;
        step();
        check_eq("pre_rst_flags", flags_q, 8'hFF);
        rst_n     = 1'b0;
        pop       = 1'b1;
        sw_wr_en  = 1'b1;
        sw_wr_data = 8'h42;
        @(posedge clk);
        #1;
        idle();
        check_eq("mrst_flags", flags_q, 8'h00);
        check_eq("mrst_empty", {7'd0, stack_empty}, 8'h01);
        check_eq("mrst_err", {7'd0, stack_err}, 8'h00);
        rst_n = 1'b1;
        pop   = 1'b1;
        step();
        check_eq("post_rst_err", {7'd0, stack_err}, 8'h01);
        check_eq("post_rst_flags", flags_q, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
